// File: rtl/ctrl_mc.sv
// Purpose : multi-cycle instruction controller, FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing.
// Latency : one state per CLK edge; first FETCH on the 2nd rising edge after RST_F release.
// Backpr. : MEM stalls on MEM_ACK for LOD/STR; no ack within MEM_TO cycles sets ERR and halts.
module ctrl_mc #(
  parameter int OPW    = 4,
  parameter int MMW    = 4,
  parameter int MM_IMM = 8,
  parameter int MEM_TO = 15
) (
  input  logic           CLK,
  input  logic           RST_F,
  input  logic [OPW-1:0] OPCODE,
  input  logic [MMW-1:0] MM,
  input  logic [MMW-1:0] STAT,
  input  logic           MEM_ACK,
  output logic           RF_WE,
  output logic           WB_SEL,
  output logic           RD_SEL,
  output logic           PC_SEL,
  output logic           PC_WRITE,
  output logic           PC_RST,
  output logic           BR_SEL,
  output logic           MM_SEL,
  output logic           DM_WE,
  output logic           MEM_REQ,
  output logic [1:0]     ALU_OP,
  output logic [2:0]     STATE,
  output logic           HALTED,
  output logic           ERR
);

  typedef enum logic [2:0] {
    START0    = 3'd0,
    START1    = 3'd1,
    FETCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    MEM       = 3'd5,
    WRITEBACK = 3'd6,
    HALT      = 3'd7
  } state_t;

  // Recognised opcodes; every other value falls through as a no-op.
  localparam logic [OPW-1:0] OP_LOD = OPW'(1);
  localparam logic [OPW-1:0] OP_STR = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6);
  localparam logic [OPW-1:0] OP_ALU = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       err_q;

  logic is_lod, is_str, is_bra, is_brr, is_bne, is_alu, is_hlt;
  logic mem_op, mm_imm, cond, taken, mem_to_hit, in_exwb;

  assign is_lod = (OPCODE == OP_LOD);
  assign is_str = (OPCODE == OP_STR);
  assign is_bra = (OPCODE == OP_BRA);
  assign is_brr = (OPCODE == OP_BRR);
  assign is_bne = (OPCODE == OP_BNE);
  assign is_alu = (OPCODE == OP_ALU);
  assign is_hlt = (OPCODE == OP_HLT);

  assign mem_op     = is_lod | is_str;
  assign mm_imm     = (MM == MMW'(MM_IMM));
  assign cond       = |(MM & STAT);
  assign taken      = ((is_bra | is_brr) & cond) | (is_bne & ~cond);
  // Last allowed MEM cycle without an ack; an ack on this cycle still wins.
  assign mem_to_hit = mem_op & ~MEM_ACK & (wait_cnt == TO_LAST);
  assign in_exwb    = (st == EXECUTE) || (st == MEM) || (st == WRITEBACK);

  // State register, MEM wait counter and sticky timeout flag.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      st       <= START0;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      case (st)
        START0:    st <= START1;
        START1:    st <= FETCH;
        FETCH:     st <= DECODE;
        DECODE:    st <= is_hlt ? HALT : EXECUTE;
        EXECUTE: begin
          wait_cnt <= 8'd0;
          st       <= taken ? FETCH : MEM;
        end
        MEM: begin
          if (!mem_op || MEM_ACK) begin
            st <= WRITEBACK;
          end else if (mem_to_hit) begin
            err_q <= 1'b1;
            st    <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WRITEBACK: st <= FETCH;
        default:   st <= HALT;
      endcase
    end
  end

  // Datapath controls decoded from present state and current instruction fields.
  always_comb begin
    RF_WE    = 1'b0;
    WB_SEL   = 1'b0;
    RD_SEL   = 1'b0;
    PC_SEL   = 1'b0;
    PC_WRITE = 1'b0;
    PC_RST   = 1'b0;
    BR_SEL   = 1'b0;
    MM_SEL   = 1'b0;
    DM_WE    = 1'b0;
    MEM_REQ  = 1'b0;
    ALU_OP   = 2'b00;
    HALTED   = 1'b0;

    PC_RST = (st == START0) || (st == START1);
    HALTED = (st == HALT);

    if (st == FETCH) PC_WRITE = 1'b1;

    if (st == EXECUTE && taken) begin
      PC_WRITE = 1'b1;
      PC_SEL   = 1'b1;
      BR_SEL   = is_bra | is_bne;
    end

    if ((st == DECODE || in_exwb) && (is_lod || (is_alu && mm_imm))) RD_SEL = 1'b1;

    if (in_exwb) begin
      if (is_alu)                      ALU_OP = mm_imm ? 2'b01 : 2'b00;
      else if (mem_op)                 ALU_OP = mm_imm ? 2'b00 : 2'b01;
      else if (is_bra|is_brr|is_bne)   ALU_OP = 2'b10;
      MM_SEL = mem_op & mm_imm;
    end

    if (st == MEM) begin
      MEM_REQ = mem_op;
      DM_WE   = is_str & MEM_ACK;
    end

    if ((st == MEM || st == WRITEBACK) && is_lod) WB_SEL = 1'b1;
    if (st == WRITEBACK) RF_WE = is_alu | is_lod;
  end

  assign STATE = st;
  assign ERR   = err_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Purpose : directed check of ctrl_mc sequencing, control decode, memory timeout and async reset.
// Latency : each step waits one rising edge and samples 1 time unit later.
// Backpr. : MEM_ACK is driven directly by the bench to stall or release MEM.
module tb_ctrl_mc;

  logic       CLK = 1'b0;
  logic       RST_F;
  logic [3:0] OPCODE, MM, STAT;
  logic       MEM_ACK;
  logic       RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL, MM_SEL, DM_WE, MEM_REQ;
  logic [1:0] ALU_OP;
  logic [2:0] STATE;
  logic       HALTED, ERR;

  int checks   = 0;
  int failures = 0;
  logic rf_seen;
  logic [11:0] ctl;

  ctrl_mc #(.OPW(4), .MMW(4), .MM_IMM(8), .MEM_TO(15)) dut (
    .CLK(CLK), .RST_F(RST_F), .OPCODE(OPCODE), .MM(MM), .STAT(STAT), .MEM_ACK(MEM_ACK),
    .RF_WE(RF_WE), .WB_SEL(WB_SEL), .RD_SEL(RD_SEL), .PC_SEL(PC_SEL), .PC_WRITE(PC_WRITE),
    .PC_RST(PC_RST), .BR_SEL(BR_SEL), .MM_SEL(MM_SEL), .DM_WE(DM_WE), .MEM_REQ(MEM_REQ),
    .ALU_OP(ALU_OP), .STATE(STATE), .HALTED(HALTED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // bit 6 is PC_RST, bits 1:0 ALU_OP
  assign ctl = {RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL, MM_SEL, DM_WE, MEM_REQ, ALU_OP};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset with RST_F low across an edge, release, and walk to FETCH.
  task automatic reset_to_fetch(input string tag);
    RST_F = 1'b0;
    #1;
    chk({tag, "_rst_state"}, STATE, 3'd0);
    chk({tag, "_rst_ctl"}, ctl, 12'h040);
    chk({tag, "_rst_err"}, ERR, 1'b0);
    step();
    RST_F = 1'b1;
    step();
    chk({tag, "_start1"}, STATE, 3'd1);
    step();
    chk({tag, "_fetch"}, STATE, 3'd2);
    chk({tag, "_fetch_pcw"}, {PC_WRITE, PC_SEL, PC_RST}, 3'b100);
  endtask

  initial begin
    RST_F = 1'b0; OPCODE = 4'd0; MM = 4'd0; STAT = 4'd0; MEM_ACK = 1'b0;
    #2;
    chk("por_state", STATE, 3'd0);
    chk("por_ctl", ctl, 12'h040);
    chk("por_halted_err", {HALTED, ERR}, 2'b00);
    reset_to_fetch("r0");

    // ALU immediate: 2,3,4,5,6,2
    OPCODE = 4'd8; MM = 4'd8;
    step(); chk("alu_dec", {STATE, RD_SEL, ALU_OP}, {3'd3, 1'b1, 2'b00});
    step(); chk("alu_ex", {STATE, RD_SEL, ALU_OP, PC_WRITE}, {3'd4, 1'b1, 2'b01, 1'b0});
    step(); chk("alu_mem", {STATE, RD_SEL, ALU_OP, MEM_REQ, RF_WE}, {3'd5, 1'b1, 2'b01, 1'b0, 1'b0});
    step(); chk("alu_wb", {STATE, RD_SEL, ALU_OP, RF_WE}, {3'd6, 1'b1, 2'b01, 1'b1});
    step(); chk("alu_back", {STATE, RF_WE}, {3'd2, 1'b0});

    // BNE taken
    OPCODE = 4'd6; MM = 4'b0011; STAT = 4'b0100;
    step(); step();
    chk("bne_t_ex", {STATE, PC_WRITE, PC_SEL, BR_SEL, ALU_OP}, {3'd4, 3'b111, 2'b10});
    step(); chk("bne_t_next", STATE, 3'd2);

    // BNE not taken
    STAT = 4'b0001;
    step(); step();
    chk("bne_n_ex", {STATE, PC_WRITE, PC_SEL, BR_SEL}, {3'd4, 3'b000});
    step(); chk("bne_n_mem", {STATE, MEM_REQ}, {3'd5, 1'b0});
    step(); chk("bne_n_wb", {STATE, RF_WE}, {3'd6, 1'b0});
    step();

    // BRR taken: relative, BR_SEL low
    OPCODE = 4'd5; MM = 4'b0011; STAT = 4'b0010;
    step(); step();
    chk("brr_t_ex", {STATE, PC_WRITE, PC_SEL, BR_SEL}, {3'd4, 3'b110});
    step(); chk("brr_t_next", STATE, 3'd2);

    // BRA taken: absolute, BR_SEL high
    OPCODE = 4'd4; MM = 4'b0100; STAT = 4'b0100;
    step(); step();
    chk("bra_t_ex", {STATE, PC_WRITE, PC_SEL, BR_SEL}, {3'd4, 3'b111});
    step(); chk("bra_t_next", STATE, 3'd2);

    // STR direct, ack held high outside MEM must be ignored, ack on 4th MEM cycle
    OPCODE = 4'd2; MM = 4'd0; STAT = 4'd0; MEM_ACK = 1'b1;
    step(); chk("str_dec", {STATE, DM_WE, MEM_REQ, RD_SEL}, {3'd3, 3'b000});
    step(); chk("str_ex", {STATE, DM_WE, MEM_REQ, ALU_OP, MM_SEL}, {3'd4, 2'b00, 2'b01, 1'b0});
    MEM_ACK = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("str_wait%0d", i), {STATE, MEM_REQ, DM_WE, ALU_OP}, {3'd5, 2'b10, 2'b01});
      step();
    end
    MEM_ACK = 1'b1; #1;
    chk("str_ack", {STATE, MEM_REQ, DM_WE, MM_SEL, ALU_OP}, {3'd5, 3'b110, 2'b01});
    step(); MEM_ACK = 1'b0; #1;
    chk("str_wb", {STATE, DM_WE, MEM_REQ, RF_WE}, {3'd6, 3'b000});
    step(); chk("str_back", STATE, 3'd2);

    // LOD immediate, immediate ack
    OPCODE = 4'd1; MM = 4'd8;
    step(); chk("lod_dec", {STATE, RD_SEL}, {3'd3, 1'b1});
    step(); chk("lod_ex", {STATE, ALU_OP, MM_SEL, RD_SEL}, {3'd4, 2'b00, 2'b11});
    step(); MEM_ACK = 1'b1; #1;
    chk("lod_mem", {STATE, MEM_REQ, WB_SEL, DM_WE, RF_WE}, {3'd5, 4'b1100});
    step(); MEM_ACK = 1'b0; #1;
    chk("lod_wb", {STATE, RF_WE, WB_SEL, MEM_REQ}, {3'd6, 3'b110});
    step(); chk("lod_back", {STATE, RF_WE}, {3'd2, 1'b0});

    // unknown opcode acts as NOOP; ack in MEM ignored, one MEM cycle
    OPCODE = 4'd3; MM = 4'd0; MEM_ACK = 1'b1;
    step(); step();
    chk("nop_ex", {STATE, ctl}, {3'd4, 12'h000});
    step(); chk("nop_mem", {STATE, ctl}, {3'd5, 12'h000});
    step(); chk("nop_wb", {STATE, ctl}, {3'd6, 12'h000});
    MEM_ACK = 1'b0;
    step();

    // LOD timeout: 15 MEM cycles then HALT with ERR
    OPCODE = 4'd1; MM = 4'd0; rf_seen = 1'b0;
    step(); step(); step();
    for (int i = 1; i < 15; i++) begin
      rf_seen |= RF_WE;
      step();
    end
    rf_seen |= RF_WE;
    chk("to_mem15", {STATE, MEM_REQ, ERR}, {3'd5, 1'b1, 1'b0});
    step();
    chk("to_halt", {STATE, ERR, HALTED}, {3'd7, 2'b11});
    chk("to_ctl", ctl, 12'h000);
    chk("to_no_rfwe", rf_seen, 1'b0);
    step(); step();
    chk("to_stay", {STATE, ERR}, {3'd7, 1'b1});

    // reset out of HALT clears ERR
    reset_to_fetch("r1");

    // HLT
    OPCODE = 4'd15;
    step(); step();
    chk("hlt_state", {STATE, HALTED, ERR}, {3'd7, 2'b10});
    chk("hlt_ctl", ctl, 12'h000);
    reset_to_fetch("r2");

    // async reset mid-MEM, away from clock edge
    OPCODE = 4'd1; MM = 4'd0;
    step(); step(); step(); step();
    chk("mid_mem", {STATE, MEM_REQ}, {3'd5, 1'b1});
    #2 RST_F = 1'b0;
    #1;
    chk("mid_rst", {STATE, ERR, PC_RST, MEM_REQ}, {3'd0, 3'b010});
    step(); RST_F = 1'b1;
    step(); step();
    chk("mid_refetch", STATE, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_mc.md
CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 Parameter OPW, 4, opcode width; opcode values below are zero-extended to OPW.
REQ-002 Parameter MMW, 4, mode/condition-mask field width.
REQ-003 Parameter MM_IMM, 8, MM value selecting immediate/direct-address mode.
REQ-004 Parameter MEM_TO, 15, max cycles in MEM awaiting MEM_ACK before timeout (1..255).
REQ-005 CLK  in  1  clock, rising edge.
REQ-006 RST_F  in  1  reset, asynchronous, active-low.
REQ-007 OPCODE  in  OPW  current instruction opcode, stable from DECODE until next FETCH.
REQ-008 MM  in  MMW  addressing mode / branch condition mask.
REQ-009 STAT  in  MMW  ALU status flags.
REQ-010 MEM_ACK  in  1  data-memory completion strobe.
REQ-011 RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL, MM_SEL, DM_WE, MEM_REQ  out  1 each  datapath controls.
REQ-012 ALU_OP  out  2  00 reg, 01 immediate, 10 non-arithmetic/branch.
REQ-013 STATE  out  3  present state encoding.
REQ-014 HALTED  out  1  high in HALT.
REQ-015 ERR  out  1  sticky memory-timeout flag.

Function
REQ-016 Opcodes: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU=8, HLT=15; any other value SHALL behave as NOOP.
REQ-017 States/encoding: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7; one transition per CLK edge.
REQ-018 Transitions: START0->START1->FETCH->DECODE; DECODE->HALT if HLT else EXECUTE; EXECUTE->FETCH if branch taken else MEM; MEM->WRITEBACK (see REQ-026); WRITEBACK->FETCH; HALT->HALT.
REQ-019 All outputs SHALL be combinational decodes of present state, OPCODE, MM, STAT, MEM_ACK and ERR; no simulation-only $stop/$display.
REQ-020 PC_RST=1 in START0 and START1 only; PC_WRITE=1 in FETCH (PC_SEL=0) and in EXECUTE for taken branch (PC_SEL=1).
REQ-021 Taken: BRA, BRR when (MM & STAT)!=0; BNE when (MM & STAT)==0; BR_SEL=1 for BRA/BNE, 0 for BRR, asserted only with PC_SEL.
REQ-022 RD_SEL=1 in DECODE..WRITEBACK for LOD, or ALU with MM==MM_IMM.
REQ-023 ALU_OP in EXECUTE..WRITEBACK: ALU -> 01 if MM==MM_IMM else 00; LOD/STR -> 00 if MM==MM_IMM else 01; branches -> 10; otherwise 00.
REQ-024 MM_SEL=1 in EXECUTE..WRITEBACK for LOD/STR with MM==MM_IMM.
REQ-025 MEM_REQ=1 throughout MEM for LOD/STR; DM_WE=1 for STR only in the MEM cycle where MEM_ACK=1 (single pulse); WB_SEL=1 for LOD in MEM and WRITEBACK.
REQ-026 MEM exit: non-memory ops leave after 1 cycle; LOD/STR leave on MEM_ACK=1; wait counter cleared on MEM entry; MEM_ACK absent for MEM_TO cycles -> ERR set, next state HALT, DM_WE not asserted.
REQ-027 MEM_ACK outside MEM, or for non-memory ops, SHALL be ignored.
REQ-028 RF_WE=1 in WRITEBACK for ALU and LOD only; exactly one cycle per instruction.
REQ-029 HALT: all controls 0, HALTED=1; exits only via RST_F.

Reset
REQ-030 RST_F=0 SHALL immediately force START0, clear ERR and wait counter, independent of CLK, including mid-MEM or in HALT.
REQ-031 During reset outputs: PC_RST=1, STATE=0, all other outputs 0.
REQ-032 After RST_F release, first FETCH SHALL occur on the 2nd rising CLK edge.

Verification
REQ-033 ALU, MM=8, MEM_ACK=0 -> STATE 2,3,4,5,6,2; ALU_OP=01 and RD_SEL=1 EXECUTE..WRITEBACK; RF_WE one pulse in WRITEBACK.
REQ-034 BNE, MM=4'b0011, STAT=4'b0100 -> taken: EXECUTE PC_WRITE=1, PC_SEL=1, BR_SEL=1, next STATE=2; STAT=4'b0001 -> not taken, enters MEM.
REQ-035 STR, MM=0, MEM_ACK after 3 MEM cycles -> MEM_REQ high 4 cycles, DM_WE one pulse on ack cycle, ALU_OP=01, MM_SEL=0.
REQ-036 LOD, MEM_ACK held 0, MEM_TO=15 -> after 15 MEM cycles STATE=7, ERR=1, HALTED=1, RF_WE never asserted.
REQ-037 HLT in DECODE -> STATE=7, all controls 0; RST_F pulse low mid-MEM -> STATE=0, ERR=0, PC_RST=1 asynchronously.
